alu_station: RTL and testbench

// Reservation station that sits directly upstream of the ALU execution unit.

---
 rtl/alu_station.sv | 188 ++++++++++++++++++
 tb/tb_alu_station.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_station.sv
// alu_station: reservation station in front of the ALU execution unit.
//
// Holds decoded ALU/branch/jump ops until both operands are known, snooping
// the ALU and load/store result broadcasts for pending operands, and issues
// at most one ready op per cycle to the ALU as a registered bundle.
//
// Ports
//   clk_in, rst_in, rdy_in   clock, sync active-high reset, global ready
//   clear                    misprediction flush (drops every held op)
//   disp_*                   dispatch interface (op, operands, tags, dest)
//   rs_full                  high when at most one entry is free
//   alu_bc_*, lsb_bc_*       result broadcast snoop ports
//   calc_enable, lhs, rhs,
//   op, rob_dep              registered issue bundle to the ALU

`ifndef ROB_WIDTH
`define ROB_WIDTH 4
`endif

module alu_station #(
    parameter int RS_SIZE = 8,
    parameter int RS_W    = 3,
    parameter int ROB_W   = `ROB_WIDTH
) (
    input  logic             clk_in,
    input  logic             rst_in,
    input  logic             rdy_in,
    input  logic             clear,
    input  logic             disp_valid,
    input  logic [8:0]       disp_op,
    input  logic [31:0]      disp_vj,
    input  logic [31:0]      disp_vk,
    input  logic             disp_qj_busy,
    input  logic [ROB_W-1:0] disp_qj,
    input  logic             disp_qk_busy,
    input  logic [ROB_W-1:0] disp_qk,
    input  logic [ROB_W-1:0] disp_dest,
    output logic             rs_full,
    input  logic             alu_bc_valid,
    input  logic [ROB_W-1:0] alu_bc_id,
    input  logic [31:0]      alu_bc_value,
    input  logic             lsb_bc_valid,
    input  logic [ROB_W-1:0] lsb_bc_id,
    input  logic [31:0]      lsb_bc_value,
    output logic             calc_enable,
    output logic [31:0]      lhs,
    output logic [31:0]      rhs,
    output logic [8:0]       op,
    output logic [ROB_W-1:0] rob_dep
);

    localparam int CNT_W = RS_W + 1;

    logic             r_busy    [RS_SIZE];
    logic [8:0]       r_op      [RS_SIZE];
    logic [31:0]      r_vj      [RS_SIZE];
    logic [31:0]      r_vk      [RS_SIZE];
    logic             r_qj_busy [RS_SIZE];
    logic [ROB_W-1:0] r_qj      [RS_SIZE];
    logic             r_qk_busy [RS_SIZE];
    logic [ROB_W-1:0] r_qk      [RS_SIZE];
    logic [ROB_W-1:0] r_dest    [RS_SIZE];

    logic             w_qj_busy_nxt [RS_SIZE];
    logic [31:0]      w_vj_nxt      [RS_SIZE];
    logic             w_qk_busy_nxt [RS_SIZE];
    logic [31:0]      w_vk_nxt      [RS_SIZE];

    logic             w_disp_qj_busy;
    logic [31:0]      w_disp_vj;
    logic             w_disp_qk_busy;
    logic [31:0]      w_disp_vk;

    logic             w_free_valid;
    logic [RS_W-1:0]  w_free_idx;
    logic [CNT_W-1:0] w_free_cnt;
    logic             w_issue_valid;
    logic [RS_W-1:0]  w_issue_idx;

    // Resolve one operand against both broadcasts. Returns {still_busy, value}.
    // ALU wins if both buses carry the same tag (cannot happen with unique
    // ROB tags, but keeps the mux deterministic).
    function automatic logic [32:0] resolve_operand(
        input logic             q_busy,
        input logic [ROB_W-1:0] q_tag,
        input logic [31:0]      value
    );
        if (q_busy && alu_bc_valid && (q_tag == alu_bc_id))
            return {1'b0, alu_bc_value};
        else if (q_busy && lsb_bc_valid && (q_tag == lsb_bc_id))
            return {1'b0, lsb_bc_value};
        else
            return {q_busy, value};
    endfunction

    always_comb begin
        logic [32:0] t;
        for (int i = 0; i < RS_SIZE; i++) begin
            t                = resolve_operand(r_qj_busy[i], r_qj[i], r_vj[i]);
            w_qj_busy_nxt[i] = t[32];
            w_vj_nxt[i]      = t[31:0];
            t                = resolve_operand(r_qk_busy[i], r_qk[i], r_vk[i]);
            w_qk_busy_nxt[i] = t[32];
            w_vk_nxt[i]      = t[31:0];
        end
        t              = resolve_operand(disp_qj_busy, disp_qj, disp_vj);
        w_disp_qj_busy = t[32];
        w_disp_vj      = t[31:0];
        t              = resolve_operand(disp_qk_busy, disp_qk, disp_vk);
        w_disp_qk_busy = t[32];
        w_disp_vk      = t[31:0];
    end

    // Free slot and issue candidate both come from pre-edge state; scanning
    // downward leaves the lowest index selected.
    always_comb begin
        w_free_valid  = 1'b0;
        w_free_idx    = '0;
        w_free_cnt    = '0;
        w_issue_valid = 1'b0;
        w_issue_idx   = '0;
        for (int i = RS_SIZE - 1; i >= 0; i--) begin
            if (!r_busy[i]) begin
                w_free_valid = 1'b1;
                w_free_idx   = RS_W'(i);
                w_free_cnt   = w_free_cnt + CNT_W'(1);
            end
            if (r_busy[i] && !r_qj_busy[i] && !r_qk_busy[i]) begin
                w_issue_valid = 1'b1;
                w_issue_idx   = RS_W'(i);
            end
        end
    end

    // One free entry of slack so dispatch can react a cycle late.
    assign rs_full = (w_free_cnt <= CNT_W'(1));

    // Entry update (wakeup, dispatch) and issue register stage
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            for (int i = 0; i < RS_SIZE; i++) r_busy[i] <= 1'b0;
            calc_enable <= 1'b0;
            lhs         <= '0;
            rhs         <= '0;
            op          <= '0;
            rob_dep     <= '0;
        end else if (!rdy_in) begin
            calc_enable <= 1'b0;
        end else if (clear) begin
            for (int i = 0; i < RS_SIZE; i++) r_busy[i] <= 1'b0;
            calc_enable <= 1'b0;
        end else begin
            for (int i = 0; i < RS_SIZE; i++) begin
                if (r_busy[i]) begin
                    r_qj_busy[i] <= w_qj_busy_nxt[i];
                    r_vj[i]      <= w_vj_nxt[i];
                    r_qk_busy[i] <= w_qk_busy_nxt[i];
                    r_vk[i]      <= w_vk_nxt[i];
                end
            end

            if (w_issue_valid) begin
                calc_enable         <= 1'b1;
                lhs                 <= r_vj[w_issue_idx];
                rhs                 <= r_vk[w_issue_idx];
                op                  <= r_op[w_issue_idx];
                rob_dep             <= r_dest[w_issue_idx];
                r_busy[w_issue_idx] <= 1'b0;
            end else begin
                calc_enable <= 1'b0;
            end

            // The free slot is never the issuing slot, so no write conflict.
            if (disp_valid && w_free_valid) begin
                r_busy[w_free_idx]    <= 1'b1;
                r_op[w_free_idx]      <= disp_op;
                r_vj[w_free_idx]      <= w_disp_vj;
                r_vk[w_free_idx]      <= w_disp_vk;
                r_qj_busy[w_free_idx] <= w_disp_qj_busy;
                r_qj[w_free_idx]      <= disp_qj;
                r_qk_busy[w_free_idx] <= w_disp_qk_busy;
                r_qk[w_free_idx]      <= disp_qk;
                r_dest[w_free_idx]    <= disp_dest;
            end
        end
    end

endmodule

// File: tb/tb_alu_station.sv
// tb_alu_station: directed self-checking bench for alu_station.
module tb_alu_station;

    localparam int ROB_W = 4;
    localparam logic [8:0] OP_ADD = 9'h001;
    localparam logic [8:0] OP_SUB = 9'h002;
    localparam logic [8:0] OP_AND = 9'h004;
    localparam logic [8:0] OP_OR  = 9'h008;
    localparam logic [8:0] OP_XOR = 9'h010;

    logic             clk_in = 1'b0;
    logic             rst_in;
    logic             rdy_in;
    logic             clear;
    logic             disp_valid;
    logic [8:0]       disp_op;
    logic [31:0]      disp_vj;
    logic [31:0]      disp_vk;
    logic             disp_qj_busy;
    logic [ROB_W-1:0] disp_qj;
    logic             disp_qk_busy;
    logic [ROB_W-1:0] disp_qk;
    logic [ROB_W-1:0] disp_dest;
    logic             rs_full;
    logic             alu_bc_valid;
    logic [ROB_W-1:0] alu_bc_id;
    logic [31:0]      alu_bc_value;
    logic             lsb_bc_valid;
    logic [ROB_W-1:0] lsb_bc_id;
    logic [31:0]      lsb_bc_value;
    logic             calc_enable;
    logic [31:0]      lhs;
    logic [31:0]      rhs;
    logic [8:0]       op;
    logic [ROB_W-1:0] rob_dep;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk_in = ~clk_in;

    alu_station #(.RS_SIZE(8), .RS_W(3), .ROB_W(ROB_W)) dut (
        .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .clear(clear),
        .disp_valid(disp_valid), .disp_op(disp_op),
        .disp_vj(disp_vj), .disp_vk(disp_vk),
        .disp_qj_busy(disp_qj_busy), .disp_qj(disp_qj),
        .disp_qk_busy(disp_qk_busy), .disp_qk(disp_qk),
        .disp_dest(disp_dest), .rs_full(rs_full),
        .alu_bc_valid(alu_bc_valid), .alu_bc_id(alu_bc_id), .alu_bc_value(alu_bc_value),
        .lsb_bc_valid(lsb_bc_valid), .lsb_bc_id(lsb_bc_id), .lsb_bc_value(lsb_bc_value),
        .calc_enable(calc_enable), .lhs(lhs), .rhs(rhs), .op(op), .rob_dep(rob_dep)
    );

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_in);
        #1;
    endtask

    task automatic idle();
        clear        = 1'b0;
        disp_valid   = 1'b0;
        disp_op      = '0;
        disp_vj      = '0;
        disp_vk      = '0;
        disp_qj_busy = 1'b0;
        disp_qj      = '0;
        disp_qk_busy = 1'b0;
        disp_qk      = '0;
        disp_dest    = '0;
        alu_bc_valid = 1'b0;
        alu_bc_id    = '0;
        alu_bc_value = '0;
        lsb_bc_valid = 1'b0;
        lsb_bc_id    = '0;
        lsb_bc_value = '0;
    endtask

    task automatic dispatch(input logic [8:0] o, input logic [31:0] vj, input logic [31:0] vk,
                            input logic qjb, input logic [ROB_W-1:0] qj,
                            input logic qkb, input logic [ROB_W-1:0] qk,
                            input logic [ROB_W-1:0] dest);
        disp_valid   = 1'b1;
        disp_op      = o;
        disp_vj      = vj;
        disp_vk      = vk;
        disp_qj_busy = qjb;
        disp_qj      = qj;
        disp_qk_busy = qkb;
        disp_qk      = qk;
        disp_dest    = dest;
    endtask

    task automatic check_issue(input string tag, input logic [31:0] e_lhs, input logic [31:0] e_rhs,
                               input logic [8:0] e_op, input logic [ROB_W-1:0] e_dep);
        check({tag, "_calc"}, 32'(calc_enable), 32'd1);
        check({tag, "_lhs"}, lhs, e_lhs);
        check({tag, "_rhs"}, rhs, e_rhs);
        check({tag, "_op"}, 32'(op), 32'(e_op));
        check({tag, "_dep"}, 32'(rob_dep), 32'(e_dep));
    endtask

    initial begin
        idle();
        rdy_in = 1'b1;
        rst_in = 1'b1;
        step();
        step();
        rst_in = 1'b0;
        check("rst_calc", 32'(calc_enable), 32'd0);
        check("rst_lhs", lhs, 32'd0);
        check("rst_rhs", rhs, 32'd0);
        check("rst_op", 32'(op), 32'd0);
        check("rst_dep", 32'(rob_dep), 32'd0);
        check("rst_full", 32'(rs_full), 32'd0);

        // Ready ADD: issue one edge after dispatch.
        dispatch(OP_ADD, 32'd5, 32'd7, 1'b0, 4'd0, 1'b0, 4'd0, 4'd1);
        step();
        check("t1_disp_calc", 32'(calc_enable), 32'd0);
        idle();
        step();
        check_issue("t1", 32'd5, 32'd7, OP_ADD, 4'd1);
        step();
        check("t1_after", 32'(calc_enable), 32'd0);

        // SUB waiting on tag 3, woken by ALU broadcast two cycles later.
        dispatch(OP_SUB, 32'd0, 32'd1, 1'b1, 4'd3, 1'b0, 4'd0, 4'd2);
        step();
        idle();
        step();
        check("t2_wait", 32'(calc_enable), 32'd0);
        alu_bc_valid = 1'b1;
        alu_bc_id    = 4'd3;
        alu_bc_value = 32'd10;
        step();
        check("t2_wake", 32'(calc_enable), 32'd0);
        idle();
        step();
        check_issue("t2", 32'd10, 32'd1, OP_SUB, 4'd2);
        step();
        check("t2_after", 32'(calc_enable), 32'd0);

        // Same-cycle bypass of both operands from the LSB broadcast.
        dispatch(OP_AND, 32'd0, 32'd0, 1'b1, 4'd6, 1'b1, 4'd6, 4'd3);
        lsb_bc_valid = 1'b1;
        lsb_bc_id    = 4'd6;
        lsb_bc_value = 32'h20;
        step();
        check("t3_disp_calc", 32'(calc_enable), 32'd0);
        idle();
        step();
        check_issue("t3", 32'h20, 32'h20, OP_AND, 4'd3);
        step();
        check("t3_after", 32'(calc_enable), 32'd0);

        // Fill all 8 entries on tag 2, then one extra dispatch that is dropped.
        for (int i = 0; i < 8; i++) begin
            dispatch(OP_ADD, 32'd0, 32'(i), 1'b1, 4'd2, 1'b0, 4'd0, 4'(i + 1));
            step();
            check($sformatf("t4_full_%0d", i), 32'(rs_full), (i >= 6) ? 32'd1 : 32'd0);
        end
        dispatch(OP_ADD, 32'd0, 32'd99, 1'b1, 4'd2, 1'b0, 4'd0, 4'd9);
        step();
        check("t4_full_over", 32'(rs_full), 32'd1);
        check("t4_no_issue", 32'(calc_enable), 32'd0);
        idle();
        alu_bc_valid = 1'b1;
        alu_bc_id    = 4'd2;
        alu_bc_value = 32'h100;
        step();
        check("t4_wake", 32'(calc_enable), 32'd0);
        idle();
        for (int i = 0; i < 8; i++) begin
            step();
            check_issue($sformatf("t4_iss%0d", i), 32'h100, 32'(i), OP_ADD, 4'(i + 1));
        end
        step();
        check("t4_after", 32'(calc_enable), 32'd0);
        check("t4_empty_full", 32'(rs_full), 32'd0);

        // Three ready entries flushed by clear before any issues.
        for (int i = 0; i < 3; i++) begin
            dispatch(OP_OR, 32'd0, 32'(i), 1'b1, 4'd4, 1'b0, 4'd0, 4'(i + 1));
            step();
        end
        idle();
        alu_bc_valid = 1'b1;
        alu_bc_id    = 4'd4;
        alu_bc_value = 32'h44;
        step();
        check("t5_wake", 32'(calc_enable), 32'd0);
        idle();
        clear = 1'b1;
        step();
        check("t5_clear_calc", 32'(calc_enable), 32'd0);
        check("t5_clear_full", 32'(rs_full), 32'd0);
        clear = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            check($sformatf("t5_post%0d", i), 32'(calc_enable), 32'd0);
        end
        dispatch(OP_ADD, 32'd1, 32'd2, 1'b0, 4'd0, 1'b0, 4'd0, 4'd5);
        step();
        idle();
        step();
        check_issue("t5_new", 32'd1, 32'd2, OP_ADD, 4'd5);
        step();
        check("t5_after", 32'(calc_enable), 32'd0);

        // rdy_in low for three cycles with three ready entries.
        for (int i = 0; i < 3; i++) begin
            dispatch(OP_XOR, 32'd0, 32'(i), 1'b1, 4'd7, 1'b0, 4'd0, 4'(i + 10));
            step();
        end
        idle();
        lsb_bc_valid = 1'b1;
        lsb_bc_id    = 4'd7;
        lsb_bc_value = 32'h33;
        step();
        check("t6_wake", 32'(calc_enable), 32'd0);
        idle();
        rdy_in = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            check($sformatf("t6_pause%0d", i), 32'(calc_enable), 32'd0);
        end
        rdy_in = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            check_issue($sformatf("t6_iss%0d", i), 32'h33, 32'(i), OP_XOR, 4'(i + 10));
        end
        step();
        check("t6_after", 32'(calc_enable), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
